// File: rtl/button_sched_pkg.sv
// Shared constants and helpers for the button event scheduler.
// Imported by the tick generator and the top level.
package button_sched_pkg;

  // Channel index width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int   EVT_PRESS_W   = 1;
  localparam logic EVT_VALID_RST = 1'b0;
  localparam logic EVT_PRESS_RST = 1'b0;
  localparam logic LOST_RST      = 1'b0;
  localparam logic PEND_RST      = 1'b0;

endpackage

// File: rtl/button_event_scheduler_sample_tick_gen.sv
// Shared sample prescaler: one-cycle tick every PRESCALE enabled cycles.
// The count freezes while en_i is low and resumes at the held phase.
module sample_tick_gen #(
  parameter int PRESCALE = 100000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick on the last count; wrap on the same edge, hold when disabled.
  always_comb begin
    tick_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Debounces N button inputs and streams press/release events
// through a single-slot-per-channel queue and round-robin arbiter.
module button_event_scheduler
  import button_sched_pkg::*;
#(
  parameter int   N_BUTTONS   = 8,
  parameter int   PRESCALE    = 100000,
  parameter int   FILTER_LEN  = 3,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [N_BUTTONS-1:0]       btn_i,
  input  logic                       en_i,
  output logic [N_BUTTONS-1:0]       state_o,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [id_w(N_BUTTONS)-1:0] evt_id_o,
  output logic                       evt_press_o,
  output logic                       lost_o,
  input  logic                       clr_lost_i
);

  localparam int IW = id_w(N_BUTTONS);

  logic                 tick;
  logic [N_BUTTONS-1:0] state_v;
  logic [N_BUTTONS-1:0] pend_v;
  logic [N_BUTTONS-1:0] ptype_v;
  logic [N_BUTTONS-1:0] cancel_v;
  logic [N_BUTTONS-1:0] taken_v;

  logic          valid_q, valid_d;
  logic [IW-1:0] id_q, id_d;
  logic          press_q, press_d;
  logic [IW-1:0] rr_q, rr_d;
  logic          lost_q, lost_d;
  logic          sel_found;
  logic [IW-1:0] sel;
  logic          load;

  sample_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (en_i),
    .tick_o  (tick)
  );

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    (* ASYNC_REG = "TRUE" *)
    logic [FILTER_LEN-1:0] chain_q;
    logic [FILTER_LEN-1:0] chain_d;
    logic state_q, state_d;
    logic pend_q, pend_d;
    logic ptype_q, ptype_d;
    logic chg;
    logic cancel;

    // Filter the sample chain and track the pending slot.
    always_comb begin
      chain_d = chain_q;
      state_d = state_q;
      pend_d  = pend_q;
      ptype_d = ptype_q;
      chg     = 1'b0;
      cancel  = 1'b0;
      if (tick) begin
        chain_d = {chain_q[FILTER_LEN-2:0], btn_i[i]};
        chg = ((&chain_d) && !state_q)
           || (~(|chain_d) && state_q);
      end
      if (taken_v[i]) begin
        pend_d = 1'b0;
      end
      if (chg) begin
        state_d = ~state_q;
        // An unreported opposite transition cancels out.
        if (pend_q && !taken_v[i]) begin
          pend_d = 1'b0;
          cancel = 1'b1;
        end else begin
          pend_d  = 1'b1;
          ptype_d = ~state_q;
        end
      end
    end

    // Per-channel registers.
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        chain_q <= {FILTER_LEN{RESET_VALUE}};
        state_q <= RESET_VALUE;
        pend_q  <= PEND_RST;
        ptype_q <= 1'b0;
      end else begin
        chain_q <= chain_d;
        state_q <= state_d;
        pend_q  <= pend_d;
        ptype_q <= ptype_d;
      end
    end

    assign state_v[i]  = state_q;
    assign pend_v[i]   = pend_q;
    assign ptype_v[i]  = ptype_q;
    assign cancel_v[i] = cancel;
  end

  // Round-robin pick and output register load.
  always_comb begin
    int t;
    logic [IW-1:0] idx;
    sel_found = 1'b0;
    sel       = '0;
    taken_v   = '0;
    valid_d   = valid_q;
    id_d      = id_q;
    press_d   = press_q;
    rr_d      = rr_q;
    load      = !valid_q || evt_ready_i;
    for (int k = 0; k < N_BUTTONS; k++) begin
      t = int'(rr_q) + k;
      if (t >= N_BUTTONS) begin
        t = t - N_BUTTONS;
      end
      idx = IW'(t);
      if (!sel_found && pend_v[idx]) begin
        sel_found = 1'b1;
        sel       = idx;
      end
    end
    if (load) begin
      valid_d = sel_found;
      if (sel_found) begin
        taken_v[sel] = 1'b1;
        id_d         = sel;
        press_d      = ptype_v[sel];
        rr_d = (sel == IW'(N_BUTTONS - 1)) ? '0 : sel + IW'(1);
      end
    end
  end

  // Sticky loss flag; a new loss beats a clear.
  always_comb begin
    lost_d = lost_q;
    if (clr_lost_i) begin
      lost_d = 1'b0;
    end
    if (|cancel_v) begin
      lost_d = 1'b1;
    end
  end

  // Output and arbiter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= EVT_VALID_RST;
      id_q    <= '0;
      press_q <= EVT_PRESS_RST;
      rr_q    <= '0;
      lost_q  <= LOST_RST;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      press_q <= press_d;
      rr_q    <= rr_d;
      lost_q  <= lost_d;
    end
  end

  assign state_o     = state_v;
  assign evt_valid_o = valid_q;
  assign evt_id_o    = id_q;
  assign evt_press_o = press_q;
  assign lost_o      = lost_q;

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Conditions and arbitrates a bank of N asynchronous button/pad inputs.
- A shared prescaler issues sample ticks; each input gets a per-channel synchronizer/agreement filter.
- Debounced press/release transitions are queued as single-slot pending events per channel.
- A round-robin arbiter drains the queue over a valid/ready event port to the controller/host logic.

Parameters:
- N_BUTTONS, 8, number of input channels (2..16).
- PRESCALE, 100000, clk cycles per sample tick (>=2).
- FILTER_LEN, 3, samples that must agree before the stable state changes (>=2).
- RESET_VALUE, 1'b0, stable-state value after reset for all channels.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; synchronous to clk_i, active-low.
- btn_i  in  N_BUTTONS  raw asynchronous inputs.
- en_i  in  1  tick enable; when low the prescaler holds its count.
- state_o  out  N_BUTTONS  debounced stable state.
- evt_valid_o  out  1  event available.
- evt_ready_i  in  1  consumer accepts the event.
- evt_id_o  out  $clog2(N_BUTTONS)  channel index of the event.
- evt_press_o  out  1  1 = became 1 (press), 0 = became 0 (release).
- lost_o  out  1  sticky: an unreported event was cancelled.
- clr_lost_i  in  1  clears lost_o.

Behaviour:
- Reset (rst_n_i low at an edge): prescaler = 0, all sample chains and state_o = {N{RESET_VALUE}}, pending = 0, evt_valid_o = 0, evt_id_o = 0, evt_press_o = 0, lost_o = 0, rr pointer = 0.
- Reset mid-operation discards all pending events and any held output. evt_valid_o drops at the first reset edge.
- Prescaler:
  - Counts 0..PRESCALE-1 while en_i = 1; holds while en_i = 0.
  - tick = en_i && count == PRESCALE-1; the count wraps to 0 on the same edge.
- Sampling, per channel:
  - Every tick edge shifts btn_i into a FILTER_LEN-deep chain (ASYNC_REG on the first two stages).
  - On a tick edge, if the new chain contents are all 1s or all 0s and differ from state_o[i], state_o[i] updates on that edge.
  - Latency from a stable input level to state_o is FILTER_LEN ticks.
  - A pulse shorter than FILTER_LEN ticks never changes state_o.
- Pending queue, per channel: bits pend[i] and ptype[i], set on the same edge that state_o[i] changes.
  - pend[i] = 0: pend <= 1, ptype <= new state.
  - pend[i] = 1 (opposite transition; same-type is impossible): pend <= 0, lost_o <= 1. Net state unchanged, event pair discarded.
- Output register:
  - Loads when evt_valid_o = 0 or (evt_valid_o && evt_ready_i).
  - Selects the first pend[j] = 1 searching from rr upward with wrap.
  - On load: evt_valid_o <= 1, evt_id_o <= j, evt_press_o <= ptype[j], pend[j] <= 0, rr <= j+1 mod N.
  - If nothing is pending on a load opportunity: evt_valid_o <= 0.
- Event timing: evt_valid_o rises 1 cycle after state_o changes (idle port). Back-to-back events stream at 1 per cycle with ready held high.
- Simultaneous events:
  - A state change on channel j on the same edge j is loaded keeps the loaded (old) event and sets pend[j] fresh for the new transition; no loss.
  - A state change on the same edge as a cancel is not possible because transitions occur only on ticks and PRESCALE >= 2.
- Stall: evt_id_o and evt_press_o stay stable while evt_valid_o && !evt_ready_i.
- lost_o: clr_lost_i clears it. If a set and a clear coincide, the set wins.
- en_i = 0 does not stop draining pending events.

Decomposition:
- Package button_sched_pkg: ID_W function ($clog2 with minimum 1), reset constants, event field widths.
- One natural sub-module, sample_tick_gen: prescaler plus en_i gating, producing a 1-cycle tick.
- Filter chains, pending logic and the arbiter stay in the top module, using generate loops per channel.

Test Plan (N_BUTTONS=4, PRESCALE=4, FILTER_LEN=3, RESET_VALUE=0, en_i=1):
- Hold rst_n_i low 5 cycles with btn_i=4'hF -> state_o=0, evt_valid_o=0, lost_o=0 throughout. After release with btn_i=4'hF, state_o=4'hF on the 3rd tick edge (cycle 12); evt_valid_o=1, id=0, press=1 at cycle 13.
- btn_i[2] high for exactly 2 ticks (8 cycles) -> state_o[2] stays 0, no event. Holding it 3 ticks -> one event id=2, press=1.
- Simultaneous press on channels 0 and 3 with rr=0 and ready=1 -> id=0 then id=3 in consecutive cycles. Repeat the release with rr=1 -> id=3 first, then id=0.
- ready=0 with channel 1 occupying the output; press then release channel 2 (6 ticks apart) -> no channel-2 event, lost_o=1. Output holds id=1 stable throughout. Pulsing clr_lost_i -> lost_o=0.
- en_i=0 for 20 cycles mid-count -> the prescaler freezes and no ticks occur. Pending events still drain. Ticks resume at the held phase.
- Assert rst_n_i low while evt_valid_o=1 with 2 pending -> evt_valid_o=0 the next cycle and no stale events after reset release.
